// File: rtl/multi_input_conditioner.sv
// multi_input_conditioner: per-channel synchroniser, debouncer and edge-pulse
// generator for asynchronous board inputs. Defining INPUTCOND_EDGECOUNT_EN adds
// per-channel saturating rising-edge counters with clearcount/edgecount ports.
module multi_input_conditioner #(
   parameter int                  CHANNELS       = 4,
   parameter int                  SYNCSTAGES     = 2,
   parameter int                  COUNTERWIDTH   = 3,
   parameter int                  WAITTIME       = 3,
   parameter logic [CHANNELS-1:0] RESETVAL       = {CHANNELS{1'b0}},
   parameter int                  EDGECOUNTWIDTH = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [CHANNELS-1:0]                noisysignal,
   output logic [CHANNELS-1:0]                conditioned,
   output logic [CHANNELS-1:0]                positiveedge,
   output logic [CHANNELS-1:0]                negativeedge,
   output logic                               anyedge
`ifdef INPUTCOND_EDGECOUNT_EN
   ,
   input  logic                               clearcount,
   output logic [CHANNELS*EDGECOUNTWIDTH-1:0] edgecount
`endif
);

   localparam logic [COUNTERWIDTH-1:0] WAIT_CNT = COUNTERWIDTH'(WAITTIME);

   logic [CHANNELS-1:0]     sync_q [SYNCSTAGES];
   logic [CHANNELS-1:0]     synced;
   logic [COUNTERWIDTH-1:0] count_q [CHANNELS];
   logic [COUNTERWIDTH-1:0] count_d [CHANNELS];
   logic [CHANNELS-1:0]     cond_d;
   logic [CHANNELS-1:0]     pos_d;
   logic [CHANNELS-1:0]     neg_d;

   assign synced = sync_q[SYNCSTAGES-1];

   // Debounce decision: agreement restarts the count, WAITTIME+1 disagreeing cycles commit.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      cond_d = conditioned;
      pos_d  = '0;
      neg_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         count_d[i] = '0;
         if (synced[i] != conditioned[i]) begin
            if (count_q[i] == WAIT_CNT) begin
               cond_d[i] = synced[i];
               pos_d[i]  = synced[i];
               neg_d[i]  = ~synced[i];
            end else begin
               count_d[i] = count_q[i] + 1'b1;
            end
         end
      end
   end

   // Synchroniser chains, debounce counters and registered level/pulse outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values and the chain shifts one stage per clock.
      if (reset) begin
         // NOTE: these arrays are a handful of flops rather than a RAM, so clearing every entry on reset is intended.
         for (int j = 0; j < SYNCSTAGES; j++) sync_q[j] <= RESETVAL;
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
         conditioned  <= RESETVAL;
         positiveedge <= '0;
         negativeedge <= '0;
         anyedge      <= 1'b0;
      end else begin
         sync_q[0] <= noisysignal;
         for (int j = 1; j < SYNCSTAGES; j++) sync_q[j] <= sync_q[j-1];
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= count_d[i];
         conditioned  <= cond_d;
         positiveedge <= pos_d;
         negativeedge <= neg_d;
         anyedge      <= |(pos_d | neg_d);
      end
   end

`ifdef INPUTCOND_EDGECOUNT_EN
   logic [EDGECOUNTWIDTH-1:0] edge_cnt_q [CHANNELS];

   // Saturating rising-edge counters; reset and clearcount win over a coincident pulse.
   always_ff @(posedge clk) begin
      if (reset || clearcount) begin
         for (int i = 0; i < CHANNELS; i++) edge_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (positiveedge[i] && !(&edge_cnt_q[i])) edge_cnt_q[i] <= edge_cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_pack
      assign edgecount[i*EDGECOUNTWIDTH +: EDGECOUNTWIDTH] = edge_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Self-checking bench for multi_input_conditioner: directed table, hand-written
// corner sequences and randomized stimulus against a window-based reference model.
`timescale 1ns/1ps
module tb_multi_input_conditioner;
   localparam int            CH  = 4;
   localparam int            SS  = 2;
   localparam int            WT  = 3;
   localparam int            ECW = 2;
   localparam logic [CH-1:0] RV1 = 4'b1111;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            clearcount = 1'b0;
   logic [CH-1:0]   noisy = '0;
   logic [CH-1:0]   cond0, pos0, neg0, cond1, pos1, neg1;
   logic            any0, any1;
   logic [CH*ECW-1:0] ecnt0, ecnt1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   multi_input_conditioner #(
      .CHANNELS(CH), .SYNCSTAGES(SS), .COUNTERWIDTH(3), .WAITTIME(WT),
      .RESETVAL(4'b0000), .EDGECOUNTWIDTH(ECW)
   ) dut0 (
      .clk(clk), .reset(reset), .noisysignal(noisy), .conditioned(cond0),
      .positiveedge(pos0), .negativeedge(neg0), .anyedge(any0)
`ifdef INPUTCOND_EDGECOUNT_EN
      , .clearcount(clearcount), .edgecount(ecnt0)
`endif
   );

   multi_input_conditioner #(
      .CHANNELS(CH), .SYNCSTAGES(SS), .COUNTERWIDTH(3), .WAITTIME(WT),
      .RESETVAL(RV1), .EDGECOUNTWIDTH(ECW)
   ) dut1 (
      .clk(clk), .reset(reset), .noisysignal(noisy), .conditioned(cond1),
      .positiveedge(pos1), .negativeedge(neg1), .anyedge(any1)
`ifdef INPUTCOND_EDGECOUNT_EN
      , .clearcount(clearcount), .edgecount(ecnt1)
`endif
   );

`ifndef INPUTCOND_EDGECOUNT_EN
   assign ecnt0 = '0;
   assign ecnt1 = '0;
`endif

   // ---------------- reference model ----------------
   // s is the raw input delayed by SS clocks (reset level before that); a channel
   // flips once the last WT+1 values of s all disagree with its current level.
   logic [CH-1:0] m_cond [2];
   logic [CH-1:0] m_pos  [2];
   logic [CH-1:0] m_neg  [2];
   logic          m_any  [2];
   int            m_cnt  [2][CH];
   logic [CH-1:0] samp_q [2][$];
   logic [CH-1:0] shist_q[2][$];

   function automatic logic [CH-1:0] rv(input int d);
      return (d == 1) ? RV1 : 4'b0000;
   endfunction

   task automatic model_step(input int d);
      logic [CH-1:0] s;
      logic [CH-1:0] old_pos;
      bit            all_diff;
      old_pos = m_pos[d];
      if (reset) begin
         samp_q[d].delete();
         shist_q[d].delete();
         for (int i = 0; i < SS; i++) samp_q[d].push_back(rv(d));
         m_cond[d] = rv(d);
         m_pos[d]  = '0;
         m_neg[d]  = '0;
         m_any[d]  = 1'b0;
         for (int c = 0; c < CH; c++) m_cnt[d][c] = 0;
      end else begin
         s = samp_q[d][0];
         samp_q[d].push_back(noisy);
         void'(samp_q[d].pop_front());
         shist_q[d].push_back(s);
         if (shist_q[d].size() > WT + 1) void'(shist_q[d].pop_front());
         m_pos[d] = '0;
         m_neg[d] = '0;
         for (int c = 0; c < CH; c++) begin
            if (shist_q[d].size() == WT + 1) begin
               all_diff = 1'b1;
               for (int k = 0; k < shist_q[d].size(); k++)
                  if (shist_q[d][k][c] == m_cond[d][c]) all_diff = 1'b0;
               if (all_diff) begin
                  m_cond[d][c] = ~m_cond[d][c];
                  if (m_cond[d][c]) m_pos[d][c] = 1'b1;
                  else              m_neg[d][c] = 1'b1;
               end
            end
         end
         m_any[d] = |(m_pos[d] | m_neg[d]);
         for (int c = 0; c < CH; c++) begin
            if (clearcount)                                  m_cnt[d][c] = 0;
            else if (old_pos[c] && m_cnt[d][c] < 2**ECW - 1) m_cnt[d][c]++;
         end
      end
   endtask

   function automatic logic [31:0] exp_vec(input int d);
      logic [CH*ECW-1:0] e;
      e = '0;
`ifdef INPUTCOND_EDGECOUNT_EN
      for (int c = 0; c < CH; c++) e[c*ECW +: ECW] = ECW'(m_cnt[d][c]);
`endif
      return {11'b0, e, m_cond[d], m_pos[d], m_neg[d], m_any[d]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // One clock: model and DUTs see the same inputs; outputs compared 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("dut0 vs model", {11'b0, ecnt0, cond0, pos0, neg0, any0}, exp_vec(0));
      check("dut1 vs model", {11'b0, ecnt1, cond1, pos1, neg1, any1}, exp_vec(1));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic          rst;
      logic [CH-1:0] in;
      logic [CH-1:0] cond;
      logic [CH-1:0] pos;
      logic [CH-1:0] neg;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int n, input logic rst, input logic [CH-1:0] in,
                      input logic [CH-1:0] cond, input logic [CH-1:0] pos, input logic [CH-1:0] neg);
      vec_t v;
      v.rst = rst; v.in = in; v.cond = cond; v.pos = pos; v.neg = neg;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      int n, both, anyc, negs, pulses;
      logic [31:0] field;

      // ch0 rise with 6-edge latency; ch1 3-cycle glitch rejected, 4-cycle high accepted then released
      add(1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(5, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(3, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add(4, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(4, 1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0011, 4'b0010, 4'b0000);
      add(3, 1'b0, 4'b0001, 4'b0011, 4'b0000, 4'b0000);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0010);
      add(1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst;
         noisy = tbl[i].in;
         tick();
         check($sformatf("table row %0d", i), {19'b0, cond0, pos0, neg0, any0},
               {19'b0, tbl[i].cond, tbl[i].pos, tbl[i].neg, |(tbl[i].pos | tbl[i].neg)});
      end

      // channels 0 and 3 rise together, then fall together
      reset = 1'b1; noisy = '0;
      tick(); tick();
      reset = 1'b0; noisy = 4'b1001;
      both = 0; anyc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pos0 == 4'b1001) both++;
         if (any0) anyc++;
      end
      check("simultaneous rise pulses", 32'(both), 32'd1);
      check("simultaneous rise anyedge", 32'(anyc), 32'd1);
      noisy = 4'b0000; negs = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (neg0 == 4'b1001) negs++;
      end
      check("simultaneous fall pulses", 32'(negs), 32'd1);

      // reset two cycles into a debounce, then full latency after release
      noisy = 4'b0001;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("reset mid-debounce level", {28'b0, cond0}, 32'd0);
      check("reset mid-debounce pulse", {28'b0, pos0}, 32'd0);
      reset = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!cond0[0] && n < 20);
      check("latency after reset", 32'(n), 32'd6);

      // inputs high through reset: RESETVAL=1111 instance must stay quiet
      noisy = 4'b1111; reset = 1'b1;
      tick(); tick(); tick();
      reset = 1'b0; pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ((pos1 | neg1) != 4'b0000 || any1) pulses++;
      end
      check("resetval high no pulses", 32'(pulses), 32'd0);
      check("resetval high level", {28'b0, cond1}, 32'hF);

`ifdef INPUTCOND_EDGECOUNT_EN
      // edge counter: saturation, clear, clear coincident with a pulse
      reset = 1'b1; noisy = '0;
      tick();
      reset = 1'b0;
      for (int r = 0; r < 5; r++) begin
         noisy[2] = 1'b1;
         for (int i = 0; i < 7; i++) tick();
         noisy[2] = 1'b0;
         for (int i = 0; i < 7; i++) tick();
      end
      field = 32'(ecnt0[2*ECW +: ECW]);
      check("edgecount saturated", field, 32'd3);
      clearcount = 1'b1;
      tick();
      clearcount = 1'b0;
      tick();
      field = 32'(ecnt0[2*ECW +: ECW]);
      check("edgecount cleared", field, 32'd0);
      noisy[2] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pos0[2] && n < 20);
      check("edge pulse before clear", {31'b0, pos0[2]}, 32'd1);
      clearcount = 1'b1;
      tick();
      clearcount = 1'b0;
      field = 32'(ecnt0[2*ECW +: ECW]);
      check("clear beats coincident edge", field, 32'd0);
      tick();
      field = 32'(ecnt0[2*ECW +: ECW]);
      check("edge not counted later", field, 32'd0);
`endif

      // randomized stimulus against the model
      reset = 1'b1; noisy = '0; clearcount = 1'b0;
      tick();
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         clearcount = ($urandom_range(0, 29) == 0);
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 5) == 0) noisy[c] = ~noisy[c];
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multi_input_conditioner.md
# multi_input_conditioner

Multi-channel, parametrised input conditioner for buttons, switches and other asynchronous external inputs. Each channel independently synchronises its raw input into the `clk` domain, debounces it with its own counter and emits one-cycle pulses on each conditioned rising and falling edge. It sits between the board-level input pins and the user logic, replacing per-pin single-channel conditioners with one block.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNCSTAGES`, 2: synchroniser flip-flop depth per channel (≥2).
- `COUNTERWIDTH`, 3: debounce counter width in bits; must satisfy 2^COUNTERWIDTH > WAITTIME.
- `WAITTIME`, 3: debounce delay in clock cycles (≥0).
- `RESETVAL`, {CHANNELS{1'b0}}: CHANNELS-bit reset level of the synchroniser chain and `conditioned`, per channel.
- `EDGECOUNTWIDTH`, 8: per-channel edge-counter width; used only with `INPUTCOND_EDGECOUNT_EN`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `noisysignal`  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- `conditioned`  out  CHANNELS  debounced, synchronised level per channel.
- `positiveedge`  out  CHANNELS  1-cycle pulse when `conditioned[i]` rises.
- `negativeedge`  out  CHANNELS  1-cycle pulse when `conditioned[i]` falls.
- `anyedge`  out  1  registered OR of all positiveedge/negativeedge bits of the same cycle, aligned with them.
- `clearcount`  in  1  (macro only) clears all edge counters.
- `edgecount`  out  CHANNELS*EDGECOUNTWIDTH  (macro only) channel i in bits [i*W+W-1 : i*W], W = EDGECOUNTWIDTH.

## Operation
- Per channel: SYNCSTAGES-deep shift chain; `s[i]` = last stage output.
- Per channel, per rising edge when not in reset, pulses default 0, then:
  - `s[i] == conditioned[i]`: counter ← 0.
  - else if counter == WAITTIME: counter ← 0; `conditioned[i]` ← `s[i]`; `positiveedge[i]` ← 1 if new value 1, else `negativeedge[i]` ← 1.
  - else counter ← counter + 1.
- Bounce: any cycle with `s[i] == conditioned[i]` restarts the count; no pulse, no level change.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- `positiveedge[i]` and `negativeedge[i]` are never both high.
- `reset` has priority over everything: sync chain ← RESETVAL, `conditioned` ← RESETVAL, counters ← 0, `positiveedge`/`negativeedge`/`anyedge` ← 0, edge counters ← 0. No pulse is generated by reset or on the first cycles after reset.
- Reset mid-debounce discards the pending count; the input is re-qualified from scratch after release.

## Timing
- Reset values: `conditioned` = RESETVAL; `positiveedge`, `negativeedge`, `anyedge`, `edgecount` = 0.
- Latency: input stable at new value before rising edge k → `conditioned` and edge pulse change at edge k + SYNCSTAGES + WAITTIME. Defaults: 6th edge counting edge k as the 1st.
- WAITTIME = 0: update on the first cycle `s` differs.
- Minimum qualified pulse width: WAITTIME+1 consecutive cycles of `s` at the new value.
- Edge pulses are exactly one cycle wide; consecutive opposite pulses on one channel are ≥ WAITTIME+1 cycles apart.
- `anyedge` is in the same cycle as the pulses that cause it.

## Configuration
- `INPUTCOND_EDGECOUNT_EN` defined: ports `clearcount` and `edgecount` exist. Each channel has an EDGECOUNTWIDTH-bit counter incremented on each `positiveedge[i]`, saturating at all-ones. `clearcount` zeroes all counters synchronously; a positive edge in the same cycle as `clearcount` is not counted. `reset` also zeroes them.
- Not defined: no counters, and the `clearcount`/`edgecount` ports are absent. All other behaviour is identical.

## Test plan
- Defaults, reset, then `noisysignal[0]` 0→1 held: `conditioned[0]`=1 and `positiveedge[0]`/`anyedge`=1 for one cycle at edge SYNCSTAGES+WAITTIME=5 after the change; other channels stay 0.
- `noisysignal[1]` high for 3 cycles then low (WAITTIME=3): no pulse, `conditioned[1]` stays 0; a 4-cycle high is accepted.
- Channels 0 and 3 rise on the same edge: both `positiveedge` bits pulse in the same cycle, one `anyedge` pulse; falling later gives `negativeedge` on both.
- `reset` asserted 2 cycles into a debounce: no pulse, `conditioned` = RESETVAL; after release with input still high, full 6-edge latency again.
- RESETVAL=4'b1111 with inputs held high through reset: no pulses after release.
- With `INPUTCOND_EDGECOUNT_EN`, EDGECOUNTWIDTH=2: 5 rising edges on channel 2 → `edgecount` field 2 = 3 (saturated); `clearcount` pulse → 0; `clearcount` coincident with an edge → 0.
